// File: rtl/wb_master_bif.sv
// Wishbone B4 classic-cycle initiator for the CPU MEM stage: one registered bus cycle per
// request, pipeline stall until ack/timeout, load data presented for one released cycle.
module wb_master_bif #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          cpu_ce_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_adr_i,
    input  logic [DW-1:0] cpu_dat_i,
    input  logic [3:0]    cpu_sel_i,
    input  logic          cpu_stall_i,
    input  logic          flush_i,
    output logic [DW-1:0] cpu_dat_o,
    output logic          stallreq_o,
    output logic          bus_err_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_stb_o,
    output logic          wb_cyc_o,
    input  logic          wb_ack_i
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [DW-1:0] rd_q, rd_d;
    logic          err_q, err_d;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            cnt_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    adr_d   = cpu_adr_i;
                    dat_d   = cpu_dat_i;
                    sel_d   = cpu_sel_i;
                    we_d    = cpu_we_i;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // flush beats ack, ack beats timeout
                if (flush_i) begin
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end else if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    rd_d    = we_q ? '0 : wb_dat_i;
                    state_d = DONE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    cyc_d   = 1'b0;
                    rd_d    = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                // holding here while stalled keeps the same access from being re-issued
                if (flush_i || !cpu_stall_i) state_d = IDLE;
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign bus_err_o = err_q;
    assign cpu_dat_o = (state_q == DONE) ? rd_q : '0;
    // gated by reset so every output reads 0 while reset is held
    assign stallreq_o = wb_rst_n_i &&
                        (((state_q == IDLE) && cpu_ce_i && !flush_i) || (state_q == BUSY));
endmodule

// File: tb/tb_wb_master_bif.sv
// Directed + randomized bench for wb_master_bif; expectations come from a transaction-level
// model (bus-cycle length, data and error derived from ack delay, flush point and TIMEOUT).
module tb_wb_master_bif;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_ce_i, cpu_we_i, cpu_stall_i, flush_i;
    logic [AW-1:0] cpu_adr_i;
    logic [DW-1:0] cpu_dat_i;
    logic [3:0]    cpu_sel_i;
    logic [DW-1:0] cpu_dat_o;
    logic          stallreq_o, bus_err_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o, wb_dat_i;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_master_bif #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_adr_i(cpu_adr_i),
        .cpu_dat_i(cpu_dat_i), .cpu_sel_i(cpu_sel_i), .cpu_stall_i(cpu_stall_i),
        .flush_i(flush_i), .cpu_dat_o(cpu_dat_o), .stallreq_o(stallreq_o),
        .bus_err_o(bus_err_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input bit e_cyc, input bit e_stall, input bit e_err,
                        input logic [31:0] e_rd);
        chk({tag, ".cyc"}, wb_cyc_o, e_cyc);
        chk({tag, ".stb"}, wb_stb_o, e_cyc);
        chk({tag, ".stallreq"}, stallreq_o, e_stall);
        chk({tag, ".bus_err"}, bus_err_o, e_err);
        chk({tag, ".cpu_dat"}, cpu_dat_o, e_rd);
    endtask

    task automatic bus_zero(input string tag);
        chk({tag, ".adr"}, wb_adr_o, 0);
        chk({tag, ".dat"}, wb_dat_o, 0);
        chk({tag, ".sel"}, wb_sel_o, 0);
        chk({tag, ".we"}, wb_we_o, 0);
    endtask

    // k: BUSY-cycle index carrying ack (>= TO means the responder never acks)
    // fa: BUSY-cycle index carrying flush (-1 none); fd: flush in the first DONE cycle
    task automatic access(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [31:0] rdata, input int k,
                          input int fa, input int stall, input bit fd);
        int          blen, dlen;
        bit          abort, err;
        logic [31:0] exp;
        abort = 0; err = 0; exp = 0;
        if (fa >= 0 && fa <= k && fa < TO) begin
            abort = 1; blen = fa + 1;
        end else if (k < TO) begin
            blen = k + 1; exp = we ? 32'h0 : rdata;
        end else begin
            blen = TO; err = 1;
        end

        cpu_ce_i = 1; cpu_we_i = we; cpu_adr_i = adr; cpu_dat_i = dat; cpu_sel_i = sel;
        flush_i = 0; cpu_stall_i = 0; wb_ack_i = 0;
        @(negedge clk) outs("req", 0, 1, 0, 0);
        @(posedge clk) #1;
        cpu_we_i = ~we; cpu_adr_i = $urandom; cpu_dat_i = $urandom; cpu_sel_i = ~sel;
        for (int i = 0; i < blen; i++) begin
            wb_ack_i = (i == k);
            flush_i  = (i == fa);
            wb_dat_i = (i == k) ? rdata : $urandom;
            @(negedge clk);
            outs("busy", 1, 1, 0, 0);
            chk("busy.adr", wb_adr_o, adr);
            chk("busy.dat", wb_dat_o, dat);
            chk("busy.sel", wb_sel_o, sel);
            chk("busy.we", wb_we_o, we);
            @(posedge clk) #1;
        end
        wb_ack_i = 0; flush_i = 0;
        if (abort) begin
            cpu_ce_i = 0; wb_ack_i = 1; wb_dat_i = $urandom;
            @(negedge clk) outs("abort", 0, 0, 0, 0);
            @(posedge clk) #1;
            wb_ack_i = 0;
        end else begin
            dlen = fd ? 1 : stall + 1;
            for (int j = 0; j < dlen; j++) begin
                cpu_ce_i    = 1;
                cpu_stall_i = fd ? 1'b1 : (j < stall);
                flush_i     = fd && (j == 0);
                wb_ack_i    = err && (j == 0);
                @(negedge clk) outs("done", 0, 0, err && (j == 0), exp);
                @(posedge clk) #1;
            end
            cpu_ce_i = 0; cpu_stall_i = 0; flush_i = 0; wb_ack_i = 0;
            @(negedge clk) outs("idle", 0, 0, 0, 0);
            @(posedge clk) #1;
        end
    endtask

    initial begin
        rst_n = 0; cpu_ce_i = 1; cpu_we_i = 0; cpu_adr_i = 0; cpu_dat_i = 0; cpu_sel_i = 0;
        cpu_stall_i = 0; flush_i = 0; wb_dat_i = 0; wb_ack_i = 0;
        #12;
        outs("rst", 0, 0, 0, 0);
        bus_zero("rst");
        cpu_ce_i = 0;
        @(posedge clk) #1 rst_n = 1;
        @(posedge clk) #1;

        // registered-ack load, store, delayed ack with stall, flush+ack, timeout
        access(0, 32'h0C00_2000, 32'h0, 4'hF, 32'h0000_0002, 1, -1, 0, 0);
        access(1, 32'h0C00_0004, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 1, -1, 0, 0);
        access(0, 32'h0C00_1000, 32'h0, 4'h3, 32'hCAFE_F00D, TO - 1, -1, 3, 0);
        access(0, 32'h0C00_3000, 32'h0, 4'hF, 32'h5555_AAAA, 1, 1, 0, 0);
        access(0, 32'h0C00_4000, 32'h0, 4'hF, 32'h7777_7777, TO, -1, 0, 0);
        access(0, 32'h0C00_5000, 32'h0, 4'h1, 32'h0BAD_0BAD, 0, -1, 2, 1);

        // flush while idle must not start a cycle
        cpu_ce_i = 1; flush_i = 1;
        @(negedge clk) outs("flidle", 0, 0, 0, 0);
        @(posedge clk) #1 cpu_ce_i = 0; flush_i = 0;
        @(negedge clk) outs("flidle2", 0, 0, 0, 0);
        @(posedge clk) #1;

        // async reset in the middle of a bus cycle
        cpu_ce_i = 1; cpu_we_i = 1; cpu_adr_i = 32'h0C00_6000; cpu_dat_i = 32'hFFFF_0000;
        cpu_sel_i = 4'hC;
        @(posedge clk) #1;
        @(posedge clk) #1;
        @(negedge clk) outs("prerst", 1, 1, 0, 0);
        #2 rst_n = 0;
        #1;
        outs("arst", 0, 0, 0, 0);
        bus_zero("arst");
        @(posedge clk) #1 cpu_ce_i = 0; cpu_we_i = 0;
        @(posedge clk) #1 rst_n = 1;
        @(posedge clk) #1;
        access(0, 32'h0C00_2000, 32'h0, 4'hF, 32'h0000_00A5, 1, -1, 0, 0);

        for (int n = 0; n < 24; n++) begin
            bit fd_r;
            int k_r, fa_r, st_r;
            k_r  = $urandom_range(0, TO);
            fa_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 1)) : -1;
            st_r = $urandom_range(0, 2);
            fd_r = ($urandom_range(0, 4) == 0);
            access(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom, k_r, fa_r, st_r, fd_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/wb_master_bif.md
# wb_master_bif

Wishbone B4 classic-cycle initiator between the CPU's memory (load/store) stage and the shared Wishbone bus carrying the UART, GPIO, ROM and PLIC responders. Converts a single-cycle CPU access request into a registered Wishbone cycle. Stalls the pipeline until the responder acks or a timeout expires, then returns read data for exactly one released cycle. Supports pipeline flush (exception/interrupt entry) aborting an in-flight access.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max BUSY cycles waiting for ack before bus error (1..255, 8-bit counter)

- wb_clk_i  in  1  bus/core clock, all state on rising edge
- wb_rst_n_i  in  1  reset, asynchronous, active-low
- cpu_ce_i  in  1  memory access request from MEM stage
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_adr_i  in  AW  byte address
- cpu_dat_i  in  DW  store data
- cpu_sel_i  in  4  byte lane select
- cpu_stall_i  in  1  MEM stage held by a later stage or external stall
- flush_i  in  1  pipeline flush; abort current access
- cpu_dat_o  out  DW  load data, valid in DONE only, else 0
- stallreq_o  out  1  stall request to pipeline control
- bus_err_o  out  1  one-cycle pulse on timeout
- wb_adr_o  out  AW  Wishbone address
- wb_dat_o  out  DW  Wishbone write data
- wb_dat_i  in  DW  Wishbone read data
- wb_sel_o  out  4  Wishbone byte select
- wb_we_o  out  1  Wishbone write enable
- wb_stb_o  out  1  Wishbone strobe
- wb_cyc_o  out  1  Wishbone cycle
- wb_ack_i  in  1  Wishbone acknowledge

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE.
- IDLE: if cpu_ce_i && !flush_i: register adr/dat/sel/we onto wb_*_o, set cyc=stb=1, clear timeout counter, → BUSY. Otherwise the Wishbone outputs stay 0.
- BUSY, priority order:
  1. flush_i → cyc=stb=0, → IDLE, no data, no error.
  2. wb_ack_i → cyc=stb=0, rd_buf ← (we ? 0 : wb_dat_i), → DONE.
  3. counter == TIMEOUT-1 → cyc=stb=0, rd_buf ← 0, bus_err_o=1 (next cycle, one pulse), → DONE.
  4. else counter+1, hold all outputs stable.
- DONE: cpu_dat_o = rd_buf, stallreq_o=0.
  - flush_i → IDLE.
  - cpu_stall_i → stay in DONE. This holds the data and prevents re-issuing the same access.
  - else → IDLE.
- stallreq_o (combinational) = (IDLE && cpu_ce_i && !flush_i) || BUSY.
- wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o change only on IDLE→BUSY. They hold their values otherwise, and cyc/stb gate validity.
- The block never asserts stb without cyc. It starts no new cycle in the edge where cyc drops.
- rd_buf cleared on reset.

## Timing
- Reset (async, wb_rst_n_i=0): state=IDLE. All outputs 0: cyc, stb, we, adr, dat, sel, cpu_dat_o, stallreq_o, bus_err_o. Counter 0.
- Request sampled at edge E0 → cyc/stb high from E0 to the edge after ack.
- With a registered-ack responder (ack one cycle after stb seen), the access takes 3 cycles from request:
  - cycle 0: request, stallreq_o=1
  - cycle 1: stb high
  - cycle 2: ack high
  - cycle 3: DONE, data valid, stallreq_o=0
- Back-to-back accesses: the next request is accepted in the IDLE cycle after DONE. There is a minimum one bus-idle cycle between cycles.
- Reset asserted mid-BUSY: cyc/stb drop immediately (async). No ack is expected after reset.
- Ack arriving in the same cycle as flush: flush wins, and the data is discarded.
- Ack arriving in the same cycle as timeout expiry: ack wins, and there is no error.
- A late ack after an abort or timeout (state IDLE/DONE) is ignored.

## Test plan
- Load from 0x0C00_2000 with a registered-ack responder returning 0x0000_0002 → cyc/stb high for 2 cycles, stallreq_o high for 3 cycles, cpu_dat_o=0x0000_0002 for 1 cycle, then 0.
- Store 0xDEAD_BEEF, sel=4'b1111, to 0x0C00_0004 → wb_we_o=1, wb_dat_o=0xDEAD_BEEF stable until ack, cpu_dat_o=0 in DONE.
- Load with ack delayed 5 cycles, cpu_stall_i high for 3 cycles after ack → remains in DONE with data held for 4 cycles, single Wishbone cycle only.
- Flush asserted in the 2nd BUSY cycle, ack in the same cycle → cyc/stb drop, IDLE, cpu_dat_o stays 0, no error.
- No ack, TIMEOUT=4 → cyc/stb high for 4 cycles, bus_err_o pulses once, cpu_dat_o=0, stallreq_o released.
- wb_rst_n_i pulled low mid-BUSY between clock edges → all outputs 0 immediately. After release, a new load completes normally.
